// File: rtl/ctrl_pkg.sv
// Shared types and datapath select encodings for the multi-cycle control sequencer.
// The FAULT state only exists when CTRL_MEM_TIMEOUT_EN is defined.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
`ifdef CTRL_MEM_TIMEOUT_EN
    ,
    ST_FAULT
`endif
  } stateT;

  // Opcodes 4'hB..4'hE are deliberately unassigned and execute as NOPs.
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_LSL  = 4'h4,
    OP_LSR  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_MOVI = 4'h8,
    OP_LDH  = 4'h9,
    OP_BEQZ = 4'hA,
    OP_HALT = 4'hF
  } opcodeT;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_MOVI,
    CLS_BRANCH,
    CLS_HALT,
    CLS_NOP
  } instrClassT;

  localparam logic [2:0] SRCA_READA   = 3'd0;
  localparam logic [2:0] SRCA_CONST64 = 3'd1;
  localparam logic [2:0] SRCA_ZERO    = 3'd2;

  localparam logic [1:0] SRCB_READB = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_ZERO  = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_LSL = 3'd4;
  localparam logic [2:0] ALU_LSR = 3'd5;

  function automatic logic isAluOp(input logic [3:0] op);
    return op <= OP_LSR;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction class, ALU operand selects and the
// memory/write-back needs that steer the sequencer through EXEC, MEM and WB.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output instrClassT instrClass,
  output logic [2:0] srcA,
  output logic [1:0] srcB,
  output logic [2:0] aluOp,
  output logic       needsMem,
  output logic       needsWb
);

  always_comb begin
    instrClass = CLS_NOP;
    srcA       = SRCA_ZERO;
    srcB       = SRCB_ZERO;
    aluOp      = ALU_ADD;
    needsMem   = 1'b0;
    needsWb    = 1'b0;

    // The six register-register ops encode their ALU function directly in the opcode.
    if (isAluOp(opcode)) begin
      instrClass = CLS_ALU;
      srcA       = SRCA_READA;
      srcB       = SRCB_READB;
      aluOp      = opcode[2:0];
      needsWb    = 1'b1;
    end else begin
      case (opcode)
        OP_LDR: begin
          instrClass = CLS_LOAD;
          srcA       = SRCA_READA;
          srcB       = SRCB_ZERO;
          needsMem   = 1'b1;
          needsWb    = 1'b1;
        end
        OP_STR: begin
          instrClass = CLS_STORE;
          srcA       = SRCA_READA;
          srcB       = SRCB_ZERO;
          needsMem   = 1'b1;
        end
        OP_MOVI: begin
          instrClass = CLS_MOVI;
          srcA       = SRCA_ZERO;
          srcB       = SRCB_IMM;
          needsWb    = 1'b1;
        end
        OP_LDH: begin
          instrClass = CLS_LOAD;
          srcA       = SRCA_CONST64;
          srcB       = SRCB_IMM;
          needsMem   = 1'b1;
          needsWb    = 1'b1;
        end
        OP_BEQZ: begin
          instrClass = CLS_BRANCH;
          srcA       = SRCA_READA;
          srcB       = SRCB_ZERO;
          aluOp      = ALU_SUB;
        end
        OP_HALT: begin
          instrClass = CLS_HALT;
        end
        default: begin
          instrClass = CLS_NOP;
        end
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) driving the 8-bit datapath.
// Defining CTRL_MEM_TIMEOUT_EN adds a MEM wait counter and a sticky FAULT state.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [8:0] Instruction,
  input  logic       ALUZero,
  input  logic       DataMemAck,
  output logic [2:0] ALUSrcAControl,
  output logic [1:0] ALUSrcBControl,
  output logic [2:0] ALUOp,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCBranch,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       MemWrite,
  output logic       DataMemReq,
  output logic       Halted,
  output logic       Fault
);

  stateT      state;
  logic [3:0] opcodeReg;
  logic [4:0] immReg;

  instrClassT instrClass;
  logic [2:0] decSrcA;
  logic [1:0] decSrcB;
  logic [2:0] decAluOp;
  logic       needsMem;
  logic       needsWb;

  // The immediate itself travels through the datapath's IR; this copy is bookkeeping only.
  logic unusedImm;
  assign unusedImm = ^immReg;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
  logic [7:0] memWaitCount;
`else
  localparam int unusedMemTimeout = MEM_TIMEOUT;
`endif

  ctrl_decode decode (
    .opcode     (opcodeReg),
    .instrClass (instrClass),
    .srcA       (decSrcA),
    .srcB       (decSrcB),
    .aluOp      (decAluOp),
    .needsMem   (needsMem),
    .needsWb    (needsWb)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      opcodeReg <= 4'd0;
      immReg    <= 5'd0;
`ifdef CTRL_MEM_TIMEOUT_EN
      memWaitCount <= 8'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          opcodeReg <= Instruction[8:5];
          immReg    <= Instruction[4:0];
          state     <= ST_DECODE;
        end
        ST_DECODE: begin
          if (instrClass == CLS_HALT)     state <= ST_HALT;
          else if (instrClass == CLS_NOP) state <= ST_FETCH;
          else                            state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (needsMem) begin
            state <= ST_MEM;
`ifdef CTRL_MEM_TIMEOUT_EN
            memWaitCount <= 8'd0;
`endif
          end else if (needsWb) begin
            state <= ST_WB;
          end else begin
            state <= ST_FETCH;
          end
        end
        // An Ack in the last counted cycle still wins over the timeout.
        ST_MEM: begin
          if (DataMemAck) begin
            state <= needsWb ? ST_WB : ST_FETCH;
          end
`ifdef CTRL_MEM_TIMEOUT_EN
          else if (memWaitCount == TIMEOUT_LAST) begin
            state <= ST_FAULT;
          end else begin
            memWaitCount <= memWaitCount + 8'd1;
          end
`endif
        end
        ST_WB: begin
          state <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
`ifdef CTRL_MEM_TIMEOUT_EN
        ST_FAULT: begin
          state <= ST_FAULT;
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs depend only on registered state and opcode (plus ALUZero for BEQZ).
  always_comb begin
    ALUSrcAControl = SRCA_ZERO;
    ALUSrcBControl = SRCB_ZERO;
    ALUOp          = ALU_ADD;
    IRWrite        = 1'b0;
    PCWrite        = 1'b0;
    PCBranch       = 1'b0;
    RegWrite       = 1'b0;
    MemToReg       = 1'b0;
    MemWrite       = 1'b0;
    DataMemReq     = 1'b0;
    Halted         = 1'b0;
    Fault          = 1'b0;

    case (state)
      ST_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      ST_EXEC: begin
        ALUSrcAControl = decSrcA;
        ALUSrcBControl = decSrcB;
        ALUOp          = decAluOp;
        if (instrClass == CLS_BRANCH) begin
          PCBranch = 1'b1;
          PCWrite  = ALUZero;
        end
      end
      ST_MEM: begin
        ALUSrcAControl = decSrcA;
        ALUSrcBControl = decSrcB;
        ALUOp          = decAluOp;
        DataMemReq     = 1'b1;
        MemWrite       = (instrClass == CLS_STORE);
      end
      ST_WB: begin
        RegWrite = 1'b1;
        MemToReg = (instrClass == CLS_LOAD);
      end
      ST_HALT: begin
        Halted = 1'b1;
      end
`ifdef CTRL_MEM_TIMEOUT_EN
      ST_FAULT: begin
        Halted = 1'b1;
        Fault  = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule
